// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: turns debounced button levels into short-press and
// long-press events, keeps one pending event of each kind per button and
// hands them out one at a time over a valid/ready port chosen round-robin.
module btn_event_arbiter #(
    parameter int N_BTN       = 4,
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int CNT_W       = 27,
    parameter int IDX_W       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_lvl,
    input  logic             ev_ready,
    output logic             ev_valid,
    output logic [IDX_W-1:0] ev_idx,
    output logic             ev_long,
    input  logic             ovr_clr,
    output logic [N_BTN-1:0] ovr_flags
);

    // The counter starts advancing on the second consecutive high sample,
    // so it reads HOLD_CYCLES-2 exactly on the HOLD_CYCLES-th high sample.
    localparam logic [CNT_W-1:0] HOLD_FIRE = CNT_W'(HOLD_CYCLES - 2);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_BTN - 1);
    localparam logic [IDX_W:0]   N_EXT     = (IDX_W+1)'(N_BTN);

    logic [N_BTN-1:0] r_prev;
    logic [CNT_W-1:0] r_hold_cnt [N_BTN];
    logic [N_BTN-1:0] r_press_pend;
    logic [N_BTN-1:0] r_long_pend;
    logic [N_BTN-1:0] r_ovr;
    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic             r_long;
    logic [IDX_W-1:0] r_rr_ptr;

    logic [N_BTN-1:0] w_press_evt;
    logic [N_BTN-1:0] w_long_evt;
    logic [N_BTN-1:0] w_gnt_press;
    logic [N_BTN-1:0] w_gnt_long;
    logic [N_BTN-1:0] w_press_ovr;
    logic [N_BTN-1:0] w_long_ovr;
    logic             w_load;
    logic             w_found;
    logic             w_gnt_is_long;
    logic [IDX_W-1:0] w_gnt_idx;
    logic [IDX_W-1:0] w_cand;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_rr_next;

    // Press on a rising level; long press on the HOLD_CYCLES-th high sample.
    always_comb begin
        w_press_evt = btn_lvl & ~r_prev;
        w_long_evt  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_long_evt[i] = btn_lvl[i] & r_prev[i] & (r_hold_cnt[i] == HOLD_FIRE);
        end
    end

    // Previous level and per-button saturating hold counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_hold_cnt[i] <= '0;
            end
        end else begin
            r_prev <= btn_lvl;
            for (int i = 0; i < N_BTN; i++) begin
                if (!btn_lvl[i]) begin
                    r_hold_cnt[i] <= '0;
                end else if (r_prev[i] && (r_hold_cnt[i] != HOLD_LAST)) begin
                    r_hold_cnt[i] <= r_hold_cnt[i] + CNT_W'(1);
                end else begin
                    r_hold_cnt[i] <= r_hold_cnt[i];
                end
            end
        end
    end

    // Round-robin search from r_rr_ptr; press beats long within a button.
    always_comb begin
        w_load        = ~r_valid | ev_ready;
        w_found       = 1'b0;
        w_gnt_is_long = 1'b0;
        w_gnt_idx     = '0;
        w_cand        = '0;
        w_sum         = '0;
        for (int k = 0; k < N_BTN; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= N_EXT) begin
                w_sum = w_sum - N_EXT;
            end else begin
                w_sum = w_sum;
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && (r_press_pend[w_cand] || r_long_pend[w_cand])) begin
                w_found       = 1'b1;
                w_gnt_idx     = w_cand;
                w_gnt_is_long = ~r_press_pend[w_cand];
            end else begin
                w_found = w_found;
            end
        end
    end

    // Grant strobes, drop detection and the pointer value after a grant.
    always_comb begin
        w_gnt_press = '0;
        w_gnt_long  = '0;
        if (w_load && w_found) begin
            if (w_gnt_is_long) begin
                w_gnt_long[w_gnt_idx] = 1'b1;
            end else begin
                w_gnt_press[w_gnt_idx] = 1'b1;
            end
        end else begin
            w_gnt_press = '0;
        end
        // An event is only dropped if its bit is still occupied next cycle.
        w_press_ovr = w_press_evt & r_press_pend & ~w_gnt_press;
        w_long_ovr  = w_long_evt & r_long_pend & ~w_gnt_long;
        if (w_gnt_idx == IDX_LAST) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = w_gnt_idx + IDX_W'(1);
        end
    end

    // Pending bits and sticky overrun flags; a new overrun beats ovr_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_press_pend <= '0;
            r_long_pend  <= '0;
            r_ovr        <= '0;
        end else begin
            r_press_pend <= w_press_evt | (r_press_pend & ~w_gnt_press);
            r_long_pend  <= w_long_evt | (r_long_pend & ~w_gnt_long);
            r_ovr        <= (r_ovr & ~{N_BTN{ovr_clr}}) | w_press_ovr | w_long_ovr;
        end
    end

    // Output event register; held stable while stalled by ev_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_long   <= 1'b0;
            r_rr_ptr <= '0;
        end else if (w_load) begin
            if (w_found) begin
                r_valid  <= 1'b1;
                r_idx    <= w_gnt_idx;
                r_long   <= w_gnt_is_long;
                r_rr_ptr <= w_rr_next;
            end else begin
                r_valid  <= 1'b0;
            end
        end else begin
            r_valid <= r_valid;
        end
    end

    assign ev_valid  = r_valid;
    assign ev_idx    = r_idx;
    assign ev_long   = r_long;
    assign ovr_flags = r_ovr;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Bench for btn_event_arbiter: directed scenarios with literal expectations
// plus randomized buttons/ready, all checked every cycle against a
// run-length based reference model of the event rules.
module tb_btn_event_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn_lvl;
    logic         ev_ready;
    logic         ev_valid;
    logic [1:0]   ev_idx;
    logic         ev_long;
    logic         ovr_clr;
    logic [N-1:0] ovr_flags;

    int checks = 0;
    int errors = 0;

    btn_event_arbiter #(
        .N_BTN(N), .HOLD_CYCLES(HOLD), .CNT_W(4), .IDX_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_lvl(btn_lvl), .ev_ready(ev_ready),
        .ev_valid(ev_valid), .ev_idx(ev_idx), .ev_long(ev_long),
        .ovr_clr(ovr_clr), .ovr_flags(ovr_flags)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int           run [N];    // consecutive high samples seen so far
    bit           m_pp [N];
    bit           m_lp [N];
    logic [N-1:0] m_ovr;
    logic [N-1:0] m_drop;
    bit           m_valid;
    int           m_idx;
    bit           m_long;
    int           m_rr;
    bit           md_load, md_found, md_gl, md_pe, md_le, md_gp, md_glg;
    int           md_gi, md_j, md_new;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                run[i] = 0; m_pp[i] = 0; m_lp[i] = 0;
            end
            m_ovr = '0; m_valid = 0; m_idx = 0; m_long = 0; m_rr = 0;
        end else begin
            md_load  = !m_valid || ev_ready;
            md_found = 0; md_gi = 0; md_gl = 0;
            if (md_load) begin
                for (int k = 0; k < N; k++) begin
                    md_j = (m_rr + k) % N;
                    if (!md_found && (m_pp[md_j] || m_lp[md_j])) begin
                        md_found = 1; md_gi = md_j; md_gl = !m_pp[md_j];
                    end
                end
            end
            m_drop = '0;
            for (int i = 0; i < N; i++) begin
                md_new = btn_lvl[i] ? ((run[i] > HOLD) ? run[i] : run[i] + 1) : 0;
                md_pe  = btn_lvl[i] && (run[i] == 0);
                md_le  = btn_lvl[i] && (md_new == HOLD);
                run[i] = md_new;
                md_gp  = md_found && !md_gl && (md_gi == i);
                md_glg = md_found && md_gl && (md_gi == i);
                if (md_pe) begin
                    if (m_pp[i] && !md_gp) m_drop[i] = 1'b1;
                    else m_pp[i] = 1;
                end else if (md_gp) m_pp[i] = 0;
                if (md_le) begin
                    if (m_lp[i] && !md_glg) m_drop[i] = 1'b1;
                    else m_lp[i] = 1;
                end else if (md_glg) m_lp[i] = 0;
            end
            m_ovr = (ovr_clr ? '0 : m_ovr) | m_drop;
            if (md_load) begin
                if (md_found) begin
                    m_valid = 1; m_idx = md_gi; m_long = md_gl; m_rr = (md_gi + 1) % N;
                end else begin
                    m_valid = 0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_valid", int'(ev_valid), int'(m_valid));
            if (m_valid) begin
                chk("model_idx", int'(ev_idx), m_idx);
                chk("model_long", int'(ev_long), int'(m_long));
            end
            chk("model_ovr", int'(ovr_flags), int'(m_ovr));
        end
    end

    // Log of accepted transfers as {idx, long}.
    logic [2:0] xq [$];
    always @(posedge clk) begin
        if (rst_n && ev_valid && ev_ready) xq.push_back({ev_idx, ev_long});
    end

    function automatic int xat(input int k);
        return (k < xq.size()) ? int'(xq[k]) : -1;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; btn_lvl = '0; ev_ready = 1'b0; ovr_clr = 1'b0;
        tick(3);
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_idx", int'(ev_idx), 0);
        chk("rst_long", int'(ev_long), 0);
        chk("rst_ovr", int'(ovr_flags), 0);
        rst_n = 1'b1; ev_ready = 1'b1;
        tick(20);
        chk("idle_xfers", xq.size(), 0);
        chk("idle_ovr", int'(ovr_flags), 0);

        // Short press on button 2: valid two edges after the rise.
        xq.delete();
        btn_lvl = 4'b0100;
        tick(1);
        chk("short_lat1", int'(ev_valid), 0);
        tick(1);
        chk("short_valid", int'(ev_valid), 1);
        chk("short_idx", int'(ev_idx), 2);
        chk("short_long", int'(ev_long), 0);
        tick(1);
        btn_lvl = '0;
        tick(20);
        chk("short_count", xq.size(), 1);
        chk("short_ev", xat(0), 4);

        // Long press on button 1 held 20 samples.
        xq.delete();
        btn_lvl = 4'b0010;
        tick(8);
        chk("long_before", int'(ev_valid), 0);
        tick(1);
        chk("long_valid", int'(ev_valid), 1);
        chk("long_idx", int'(ev_idx), 1);
        chk("long_flag", int'(ev_long), 1);
        tick(11);
        btn_lvl = '0;
        tick(10);
        chk("long_count", xq.size(), 2);
        chk("long_ev0", xat(0), 2);
        chk("long_ev1", xat(1), 3);

        // Asynchronous reset while an event is presented.
        ev_ready = 1'b0;
        btn_lvl = 4'b0001;
        tick(2);
        chk("arst_pre", int'(ev_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(ev_valid), 0);
        btn_lvl = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2);

        // Round robin: 0,1,3 together from rr_ptr=0, then 0,3.
        xq.delete();
        btn_lvl = 4'b1011;
        tick(5);
        chk("rr_hold_idx", int'(ev_idx), 0);
        ev_ready = 1'b1;
        tick(1);
        btn_lvl = '0;
        tick(10);
        btn_lvl = 4'b1001;
        tick(3);
        btn_lvl = '0;
        tick(10);
        chk("rr_count", xq.size(), 5);
        chk("rr_ev0", xat(0), 0);
        chk("rr_ev1", xat(1), 2);
        chk("rr_ev2", xat(2), 6);
        chk("rr_ev3", xat(3), 0);
        chk("rr_ev4", xat(4), 6);

        // Backpressure: event held stable, one ready pulse moves one event.
        xq.delete();
        ev_ready = 1'b0;
        btn_lvl = 4'b1000;
        tick(2);
        btn_lvl = 4'b0001;
        tick(1);
        btn_lvl = '0;
        tick(1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", int'(ev_valid), 1);
            chk("bp_idx", int'(ev_idx), 3);
            chk("bp_long", int'(ev_long), 0);
            tick(1);
        end
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        chk("bp_one", xq.size(), 1);
        chk("bp_ev", xat(0), 6);
        chk("bp_next_valid", int'(ev_valid), 1);
        chk("bp_next_idx", int'(ev_idx), 0);
        ev_ready = 1'b1;
        tick(5);

        // Overrun: second press on button 2 while the first is still queued.
        xq.delete();
        ev_ready = 1'b0;
        btn_lvl = 4'b0010; tick(2);
        btn_lvl = '0;      tick(1);
        btn_lvl = 4'b0100; tick(1);
        btn_lvl = '0;      tick(1);
        btn_lvl = 4'b0100; tick(1);
        btn_lvl = '0;      tick(1);
        chk("ovr_set", int'(ovr_flags), 4);
        ev_ready = 1'b1;
        tick(10);
        chk("ovr_count", xq.size(), 2);
        chk("ovr_ev0", xat(0), 2);
        chk("ovr_ev1", xat(1), 4);
        chk("ovr_sticky", int'(ovr_flags), 4);
        ovr_clr = 1'b1; tick(1);
        ovr_clr = 1'b0;
        chk("ovr_clr", int'(ovr_flags), 0);

        // Randomized traffic, checked each cycle by the model.
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 9) == 0) btn_lvl[b] = ~btn_lvl[b];
            end
            if (((c / 300) % 2) == 1) ev_ready = ($urandom_range(0, 9) < 2);
            else ev_ready = ($urandom_range(0, 9) < 8);
            ovr_clr = ($urandom_range(0, 49) == 0);
            if (c == 2500) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
- Collects debounced button levels from N per-button debounce blocks.
- Detects a short-press event (rising edge) and a long-press event (level held HOLD_CYCLES cycles) per button.
- Queues one pending event of each kind per button and shares a single event output between all buttons using a round-robin arbiter with a valid/ready handshake.
- Sits between the button debounce front-end and the control FSM that consumes user commands.

Parameters:
N_BTN, 4, number of button inputs (2..16)
HOLD_CYCLES, 100_000_000, consecutive high samples that define a long press (1 s at 100 MHz); minimum 2
CNT_W, 27, hold counter width; must hold HOLD_CYCLES-1
IDX_W, 2, width of ev_idx; equals clog2(N_BTN)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  reset, asynchronous, active-low
btn_lvl  in  N_BTN  debounced, already-synchronised button levels, 1 = pressed
ev_ready  in  1  consumer accepts the current event
ev_valid  out  1  event present on ev_idx/ev_long
ev_idx  out  IDX_W  button index of the event
ev_long  out  1  0 = short press, 1 = long press
ovr_clr  in  1  clears ovr_flags
ovr_flags  out  N_BTN  sticky per-button overrun: an event was dropped

Behaviour:
- Reset (rst_n low, asynchronous): all registers clear immediately.
  - Cleared state: ev_valid=0, ev_idx=0, ev_long=0, ovr_flags=0, all pending bits 0, hold counters 0, previous-level registers 0, rr_ptr=0.
  - Releasing reset with a button already high produces a press event, because the previous-level register is 0.
- Edge detect: prev[i] <= btn_lvl[i] every cycle. press_evt[i] = btn_lvl[i] & ~prev[i].
- Hold counter, per button:
  - If btn_lvl[i]=0, hold_cnt[i] <= 0.
  - Otherwise it increments, saturating at HOLD_CYCLES-1.
  - long_evt[i] fires in the single cycle where btn_lvl[i]=1 and hold_cnt[i]==HOLD_CYCLES-2, which is the HOLD_CYCLES-th consecutive high sample.
  - Exactly one long event per hold. Releasing earlier gives no long event.
- Pending bits press_pend[i] and long_pend[i]:
  - Set on the corresponding event; cleared when granted to the output register.
  - Same-cycle event and grant on the same bit: the bit stays set. The new event is kept and there is no overrun.
  - Event while the bit is already set and not being granted: the event is dropped and ovr_flags[i] <= 1.
  - ovr_clr clears all ovr_flags. If ovr_clr and an overrun occur in the same cycle, the overrun wins.
- Output register and handshake:
  - A load is allowed when ev_valid=0, or when ev_valid=1 and ev_ready=1.
  - On a load, if any pending bit is set, select a button by round robin:
    - Search indices rr_ptr, rr_ptr+1, ... modulo N_BTN.
    - The first index with press_pend or long_pend set wins.
    - Within one button, press has priority over long.
  - Load ev_idx and ev_long, set ev_valid=1, clear the granted pending bit, and set rr_ptr <= (granted index + 1) mod N_BTN.
  - If nothing is pending, ev_valid <= 0.
  - While ev_valid=1 and ev_ready=0, ev_idx and ev_long are held stable.
  - Back-to-back: with ev_ready held high, one event transfers per cycle.
- Latency: the first posedge at which btn_lvl[i]=1 is sampled sets press_pend. With the output free, ev_valid=1 with that event after the next posedge, i.e. 2 clock edges after the level rises.
- Pending events are never lost by arbitration. Only same-kind, same-button repeats can overrun.
- Width rule: ev_idx = granted index truncated to IDX_W. N_BTN must be at most 2^IDX_W.

Test Plan:
- Reset/idle: hold rst_n=0, then release with btn_lvl=0 -> ev_valid=0, ovr_flags=0 for 20 cycles. Assert rst_n=0 mid-event -> ev_valid drops in the same cycle (asynchronous).
- Short press (HOLD_CYCLES=8): btn_lvl[2] high for 3 cycles, ev_ready=1 -> exactly one event, idx=2, long=0, appearing 2 edges after the rise. No long event.
- Long press (HOLD_CYCLES=8): btn_lvl[1] high for 20 cycles -> events (1,0) then (1,1). The long event is valid 1 cycle after the 8th high sample. No further events.
- Round robin: btn_lvl[0], [1] and [3] rise in the same cycle with ev_ready=0 for 5 cycles, then ev_ready=1 -> order idx 0, 1, 3. Then raise [0] and [3] together with rr_ptr=0 (after idx 3 was granted) -> order 0, 3.
- Backpressure/stability: ev_ready=0 for 10 cycles with ev_valid=1 -> idx and long are unchanged. One ev_ready pulse -> exactly one transfer.
- Overrun: ev_ready=0, then pulse btn_lvl[2] twice (press, release, press) -> ovr_flags=4'b0100, and only one press for idx 2 is delivered. Then ovr_clr=1 for 1 cycle -> ovr_flags=0.
